ddr_nto1_ser_gearbox: RTL and testbench
=======================================

# ddr_nto1_ser_gearbox

Parametrised N:1 parallel-to-serial gearbox for the DDR transmit datapath. It takes NUM_CH channels of IN_W-bit parallel words over a valid/ready handshake and emits one OUT_W-bit slice per channel per clock, RATIO slices per word. It sits in the digital domain ahead of the analog 2:1 serializer cells. It adds a one-entry holding buffer for gapless streaming, per-word bit-order selection, an idle fill pattern, and a sticky stream-gap flag.

## Interface
- NUM_CH, 1: number of independent lanes serialized in lockstep.
- IN_W, 8: parallel word width per channel.
- RATIO, 4: slices per word. Must be ≥2 and divide IN_W; OUT_W = IN_W/RATIO.
- i_clk  input  1  sole clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  parallel word present.
- o_ready  output  1  gearbox accepts the word this cycle.
- i_data  input  NUM_CH*IN_W  channel k word at [k*IN_W +: IN_W].
- i_msb_first  input  1  bit order for the word being accepted; 0 = LSB slice first.
- i_idle_pat  input  OUT_W  slice value driven on every channel while idle.
- i_clr_gap  input  1  clears o_gap.
- o_data  output  NUM_CH*OUT_W  channel k slice at [k*OUT_W +: OUT_W].
- o_valid  output  1  o_data carries a word slice.
- o_first  output  1  o_data carries slice 0 of a word.
- o_gap  output  1  sticky: the stream ran dry after at least one word.

## Operation
- State: hold register (word, mode bit, hold_vld), shifter (word, mode bit), phase counter cnt of width $clog2(RATIO), busy, idle_pat_q, started, gap.
- Accept: i_valid & o_ready at an edge writes i_data and i_msb_first into hold and sets hold_vld.
- o_ready = ~i_rst & (~hold_vld | load). load = hold_vld & (~busy | cnt==RATIO-1). A word is accepted on the same edge the hold empties.
- Load: on load, hold moves to the shifter, cnt is set to 0, busy is set, and started is set. hold_vld clears unless a new word is accepted on the same edge.
- Shift: while busy and not last, cnt increments. At cnt==RATIO-1 without load, busy clears and cnt returns to 0.
- Slice j of channel k: LSB mode outputs word[j*OUT_W +: OUT_W]; MSB mode outputs word[(RATIO-1-j)*OUT_W +: OUT_W]. The mode is latched per word at accept, so changing i_msb_first never affects a word already accepted.
- o_data = busy ? current slice : {NUM_CH{idle_pat_q}}. idle_pat_q registers i_idle_pat every cycle. o_valid = busy. o_first = busy & cnt==0.
- Gap: gap is set when busy & cnt==RATIO-1 & ~hold_vld & started. i_clr_gap clears gap; if set and clear occur on the same edge, set wins. o_gap = gap.
- State FSM: IDLE (busy=0) → SHIFT on load. SHIFT → SHIFT (reload) at the last slice if hold_vld, otherwise → IDLE.

## Timing
- Reset: all registers are cleared. o_ready=0 while i_rst=1 and 1 on the first cycle after release. Outputs are o_data=0, o_valid=0, o_first=0, o_gap=0.
- Latency: word accepted at edge E0 into an idle block → loaded at E1 → slice 0 visible in the cycle after E1. Slice j is visible after edge E1+j.
- Throughput: with i_valid held high, one word every RATIO cycles. o_valid stays high with no bubble. o_ready pulses high for one cycle per word once the hold is full.
- Backpressure: when hold is full and the shifter is mid-word, o_ready=0 and i_data is ignored.
- Reset mid-word: the shifter and hold contents are discarded. The next cycle shows idle pattern 0 with o_valid=0, and no partial word resumes.
- i_idle_pat appears on o_data one cycle after it changes.

## Test plan
- Use NUM_CH=2, IN_W=8, RATIO=4 for all scenarios.
- **Single word, LSB first:** i_data=16'h1EB4, i_msb_first=0, one accept → o_data = 4'h8, 4'hD, 4'h7, 4'h2 on consecutive cycles. o_first is high on 4'h8 only. Then the idle pattern appears and o_gap=1.
- **Same word, MSB first:** o_data = 4'h2, 4'h7, 4'hD, 4'h8. Toggling i_msb_first during the word does not change its order.
- **Back-to-back stream of 5 words:** i_valid constant → 20 consecutive o_valid cycles, o_first every 4th cycle, o_gap stays 0 until the stream ends.
- **Idle and reset:** i_idle_pat=2'b10 with no traffic → o_data=4'hA after one cycle and o_valid=0. Assert i_rst at slice 2 → next cycle o_data=0, o_valid=0, o_ready=0; after release, idle resumes with no stale slices.
- **Gap flag:** after a gap, o_gap=1. i_clr_gap on the same edge as a new gap event leaves o_gap=1. A clear with no event gives o_gap=0.
- **Backpressure:** with the hold full mid-word, o_ready=0 and the presented word is not taken. It is accepted on the edge of the last slice, and output continues without a bubble.

Source files
------------

// File: rtl/ddr_nto1_ser_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ddr_nto1_ser_gearbox                                          |
// | Brief    : N:1 parallel-to-serial gearbox feeding the analog 2:1 DDR     |
// |            serializer cells. One-entry hold buffer for gapless streaming,|
// |            per-word bit order, idle fill pattern, sticky stream-gap flag.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ddr_nto1_ser_gearbox #(
   parameter int NUM_CH = 1,
   parameter int IN_W   = 8,
   parameter int RATIO  = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [NUM_CH*IN_W-1:0]           i_data,
   input  logic                             i_msb_first,
   input  logic [IN_W/RATIO-1:0]            i_idle_pat,
   input  logic                             i_clr_gap,
   output logic [NUM_CH*(IN_W/RATIO)-1:0]   o_data,
   output logic                             o_valid,
   output logic                             o_first,
   output logic                             o_gap
);

   localparam int OUT_W = IN_W / RATIO;
   localparam int CNT_W = $clog2(RATIO);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

   // IDLE: shifter empty, idle pattern on the lanes. SHIFT: a word is being sliced.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                     state;
   logic [NUM_CH*IN_W-1:0]     hold_word;
   logic                       hold_msb;
   logic                       hold_vld;
   logic [NUM_CH*IN_W-1:0]     sh_word;
   logic                       sh_msb;
   logic [CNT_W-1:0]           cnt;
   logic [OUT_W-1:0]           idle_pat_q;
   logic                       started;
   logic                       gap;

   logic                       busy;
   logic                       is_last;
   logic                       load;
   logic                       accept;
   logic                       gap_set;
   logic [CNT_W-1:0]           sel;
   logic [NUM_CH*OUT_W-1:0]    slice;

   assign busy    = (state == ST_SHIFT);
   assign is_last = (cnt == LAST_CNT);
   // The hold drains into the shifter when the shifter is free or finishing,
   // so a fresh word can land in the hold on that very same edge.
   assign load    = hold_vld & (~busy | is_last);
   assign o_ready = ~i_rst & (~hold_vld | load);
   assign accept  = i_valid & o_ready;
   // Stream ran dry: last slice going out with nothing queued behind it.
   assign gap_set = busy & is_last & ~hold_vld & started;

   // MSB-first mode walks the slices from the top of the word downwards.
   assign sel = sh_msb ? (LAST_CNT - cnt) : cnt;

   // Per-lane slice selection out of the shifter word.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign slice[k*OUT_W +: OUT_W] = sh_word[k*IN_W + int'(sel)*OUT_W +: OUT_W];
   end

   assign o_data  = busy ? slice : {NUM_CH{idle_pat_q}};
   assign o_valid = busy;
   assign o_first = busy & (cnt == '0);
   assign o_gap   = gap;

   // Hold buffer, shifter, phase counter, FSM, idle pattern and gap flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         hold_word  <= '0;
         hold_msb   <= 1'b0;
         hold_vld   <= 1'b0;
         sh_word    <= '0;
         sh_msb     <= 1'b0;
         cnt        <= '0;
         idle_pat_q <= '0;
         started    <= 1'b0;
         gap        <= 1'b0;
      end else begin
         idle_pat_q <= i_idle_pat;

         if (accept) begin
            hold_word <= i_data;
            hold_msb  <= i_msb_first;
         end

         if (load) begin
            sh_word  <= hold_word;
            sh_msb   <= hold_msb;
            cnt      <= '0;
            state    <= ST_SHIFT;
            started  <= 1'b1;
            hold_vld <= accept;
         end else begin
            if (accept) begin
               hold_vld <= 1'b1;
            end
            if (state == ST_SHIFT) begin
               if (is_last) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         end

         // A new gap event takes priority over a simultaneous clear.
         if (gap_set) begin
            gap <= 1'b1;
         end else if (i_clr_gap) begin
            gap <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr_nto1_ser_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ddr_nto1_ser_gearbox                                       |
// | Brief    : Scoreboard bench for ddr_nto1_ser_gearbox. The driver keeps a |
// |            timeline model (accept cycle, start cycle, end of stream) and |
// |            queues expected slices; a monitor pops them as they appear.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ddr_nto1_ser_gearbox;

   localparam int NUM_CH = 2;
   localparam int IN_W   = 8;
   localparam int RATIO  = 4;
   localparam int OUT_W  = IN_W / RATIO;
   localparam int DW     = NUM_CH * IN_W;
   localparam int OW     = NUM_CH * OUT_W;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid;
   logic            ready;
   logic [DW-1:0]   data;
   logic            msb_first;
   logic [OUT_W-1:0] idle_pat;
   logic            clr_gap;
   logic [OW-1:0]   out_data;
   logic            out_valid;
   logic            first;
   logic            gap;

   ddr_nto1_ser_gearbox #(
      .NUM_CH (NUM_CH),
      .IN_W   (IN_W),
      .RATIO  (RATIO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (valid),
      .o_ready     (ready),
      .i_data      (data),
      .i_msb_first (msb_first),
      .i_idle_pat  (idle_pat),
      .i_clr_gap   (clr_gap),
      .o_data      (out_data),
      .o_valid     (out_valid),
      .o_first     (first),
      .o_gap       (gap)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      logic [OW-1:0] data;
      logic          first;
   } slice_t;

   slice_t          sb[$];

   int              cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Timeline model: cycle in which the word sitting in the hold was accepted,
   // cycle its first slice goes out, and first cycle after the scheduled stream.
   int              h_acc     = -100;
   int              h_start   = -100;
   int              next_free = 0;
   logic            gap_m     = 1'b0;
   logic [OUT_W-1:0] idle_m   = '0;
   logic            exp_rdy   = 1'b0;
   bit              last_acc  = 1'b0;
   bit              done      = 1'b0;
   int              timeouts  = 0;
   int              tests     = 0;
   int              fails     = 0;

   function automatic logic [OW-1:0] slice_of(input logic [DW-1:0] w, input bit msb, input int j);
      logic [OW-1:0]   r;
      logic [IN_W-1:0] chw;
      int              eff;
      r   = '0;
      eff = msb ? (RATIO - 1 - j) : j;
      for (int k = 0; k < NUM_CH; k++) begin
         chw = w[k*IN_W +: IN_W];
         r[k*OUT_W +: OUT_W] = OUT_W'(chw >> (eff * OUT_W));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: predict this cycle's ready, then apply the edge to the model.
   task automatic step();
      int     c;
      int     s;
      bit     acc;
      bit     gset;
      slice_t e;
      c       = cyc;
      exp_rdy = !rst && !((h_acc + 1 <= c) && (c <= h_start - 2));
      acc     = valid && exp_rdy;
      gset    = !rst && (next_free == c + 1) && (h_start != c + 1);
      @(negedge clk);
      #1;
      if (rst) begin
         sb.delete();
         h_acc     = -100;
         h_start   = -100;
         next_free = 0;
         gap_m     = 1'b0;
         idle_m    = '0;
      end else begin
         if (acc) begin
            s = (c + 2 > next_free) ? c + 2 : next_free;
            for (int j = 0; j < RATIO; j++) begin
               e.cyc   = s + j;
               e.data  = slice_of(data, msb_first, j);
               e.first = (j == 0);
               sb.push_back(e);
            end
            h_acc     = c;
            h_start   = s;
            next_free = s + RATIO;
         end
         if (gset)         gap_m = 1'b1;
         else if (clr_gap) gap_m = 1'b0;
         idle_m = idle_pat;
      end
      last_acc = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_word(input logic [DW-1:0] w, input bit msb, input bit keep_valid);
      int n;
      n         = 0;
      valid     = 1'b1;
      data      = w;
      msb_first = msb;
      do begin
         step();
         n++;
      end while (!last_acc && n < 4 * RATIO);
      if (!last_acc) timeouts++;
      if (!keep_valid) valid = 1'b0;
   endtask

   // Monitor: compare every cycle against the scoreboard head or the idle state.
   initial begin
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
               check("valid", 32'(out_valid), 32'd1);
               check("slice", 32'(out_data), 32'(sb[0].data));
               check("first", 32'(first), 32'(sb[0].first));
               void'(sb.pop_front());
            end else begin
               check("valid", 32'(out_valid), 32'd0);
               check("idle_data", 32'(out_data), 32'({NUM_CH{idle_m}}));
               check("first", 32'(first), 32'd0);
            end
            check("ready", 32'(ready), 32'(exp_rdy));
            check("gap", 32'(gap), 32'(gap_m));
         end
         if (done) begin
            check("drain", 32'(sb.size()), 32'd0);
            check("timeouts", 32'(timeouts), 32'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Driver: directed scenarios followed by randomized traffic.
   initial begin
      rst       = 1'b1;
      valid     = 1'b0;
      data      = '0;
      msb_first = 1'b0;
      idle_pat  = '0;
      clr_gap   = 1'b0;
      @(posedge clk);
      #1;
      idle(2);
      rst = 1'b0;
      idle(2);

      // single word, LSB first, then idle with gap raised
      send_word(16'h1EB4, 1'b0, 1'b0);
      idle(8);

      // same word MSB first, mode input toggled while it is shifting
      send_word(16'h1EB4, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         msb_first = ~msb_first;
         step();
      end
      idle(2);

      // clear with no concurrent event
      clr_gap = 1'b1;
      step();
      clr_gap = 1'b0;
      step();

      // back-to-back stream of five words
      for (int i = 0; i < 5; i++) begin
         send_word(DW'(16'h3C5A + i * 16'h1357), (i % 2) == 1, i < 4);
      end
      idle(8);

      // idle pattern with no traffic
      idle_pat = 2'b10;
      idle(3);

      // reset while slice 2 is on the lanes
      send_word(16'hC35A, 1'b0, 1'b0);
      idle(3);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(4);

      // clear held through a gap event: set wins, then clear takes effect
      clr_gap = 1'b1;
      send_word(16'h5A5A, 1'b0, 1'b0);
      idle(6);
      clr_gap = 1'b0;
      send_word(16'h0FF0, 1'b1, 1'b0);
      idle(6);
      clr_gap = 1'b1;
      step();
      clr_gap = 1'b0;
      step();

      // backpressure: hold full mid-word, third word waits for the last slice
      send_word(16'hA1B2, 1'b0, 1'b1);
      send_word(16'hC3D4, 1'b1, 1'b1);
      send_word(16'hE5F6, 1'b0, 1'b1);
      send_word(16'h1728, 1'b1, 1'b0);
      idle(10);

      // randomized traffic with occasional resets and clears
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 99) < 2);
         valid     = ($urandom_range(0, 99) < 65);
         data      = DW'($urandom);
         msb_first = 1'($urandom);
         idle_pat  = OUT_W'($urandom);
         clr_gap   = ($urandom_range(0, 9) == 0);
         step();
      end
      rst     = 1'b0;
      valid   = 1'b0;
      clr_gap = 1'b0;
      idle(12);

      done = 1'b1;
      step();
   end

endmodule
`default_nettype wire
